srt4_ctrl_unit: RTL and testbench
=================================

// Module: srt4_ctrl_unit
// PURPOSE
//  Control unit (sequencer) for the radix-4 SRT divider datapath.
//  Sits beside the P, A, A' and B registers and the P adder.
//  Drives strobes c0..c14 that normalise, iterate, correct, convert and denormalise.
//  Takes status bits back from the datapath, with busy/done/div_by_zero toward the host.
// PARAMETERS
//  WIDTH   8          operand width (A, A', B); P is WIDTH+1
//  STEPS   WIDTH/2    radix-4 iterations (2 quotient bits each)
//  CNT_W   3          width of normalisation counter (max WIDTH-1 shifts)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       begin a division; sampled only in IDLE
//  b_msb        in   1       B[WIDTH-1], normalisation status
//  b_zero       in   1       B == 0
//  p_top        in   4       P[8:5], signed estimate for digit selection
//  p_sign       in   1       P[8], remainder sign after last step
//  c            out  15      strobes; c[i] drives datapath ci; registered
//  busy         out  1       high from the cycle after start until done
//  done         out  1       one-cycle pulse, results valid in A (quotient) and P (remainder)
//  div_by_zero  out  1       set with done when b_zero; cleared on next start
// BEHAVIOUR
//  Reset (rst_n=0, any time): state IDLE, c=0, busy=0, done=0, div_by_zero=0, counters=0.
//   An operation in progress is aborted.
//  All outputs are registered Moore outputs. Each asserted strobe lasts exactly one cycle.
//  States and strobes:
//   IDLE   : start=1 -> INIT, else stay. start outside IDLE is ignored.
//   INIT   : c0=1 (clear P/A', load A), c1=1 (load B); -> NORM
//   NORM   : b_zero -> DONE with div_by_zero=1.
//            b_msb=0 and norm_cnt<WIDTH-1 -> c2=1, norm_cnt++, stay.
//            else -> STEP (no strobe in exit cycle).
//   STEP   : c3=1; digit d from p_top (signed) puts quotient bits:
//            >=+3 -> d=+2, c7; +1..+2 -> d=+1, c4; 0/-1 -> d=0;
//            -2..-3 -> d=-1, c5; <=-4 -> d=-2, c6.
//            step_cnt++; d!=0 -> ADD; else last step -> CORR; else STEP.
//   ADD    : c8=1; c9=1 if d>0 (subtract), c10=1 if |d|=2 (use 2B).
//            step_cnt==STEPS -> CORR, else STEP.
//   CORR   : if p_sign: c8=1, c11=1 (P<=P+B), c12=1 (A'<=A'+1). -> CONV
//   CONV   : c13=1 (A <= A - A'). norm_cnt>0 -> DENORM, else DONE.
//   DENORM : c14=1, norm_cnt--; norm_cnt reaches 0 -> DONE.
//   DONE   : done=1, busy=0 next; -> IDLE.
//  Mutual exclusion: c4/c5/c6/c7 at most one, only with c3.
//   c9/c10/c11 only with c8. c0,c2,c3,c8,c14 never together.
//  Latency: 13 cycles start->done for b_msb=1, all digits nonzero, no correction.
//   +2 cycles per normalisation shift; -1 per zero digit; +0 for correction.
//  Back-to-back: start in cycle after done is accepted.
// STRUCTURE
//  srt4_pkg: state enum, localparams for strobe indices C0..C14, digit encoding
//   (D_M2..D_P2), p_top threshold constants.
//  Sub-module srt4_qsel: combinational p_top -> digit + c4/c5/c6/c7 mask.
//  Top: FSM, step_cnt, norm_cnt, registered strobe vector.
// TESTING
//  1. start, b_msb=1, p_top=+3 every step -> c3+c7 then c8+c9+c10 x4; done at cycle 13.
//  2. b_msb=0 for 3 cycles -> three c2 pulses, later three c14 pulses; done at cycle 19.
//  3. b_zero=1 in NORM -> done=1 and div_by_zero=1; no c3/c8 ever asserted.
//  4. p_top=0 every step, p_sign=1 -> four lone c3 pulses; CORR asserts c8+c11+c12; done cycle 9.
//  5. rst_n low during ADD -> c=0 immediately; start after release runs full sequence.
//  6. start held high while busy and at done -> ignored until IDLE; one-hot/exclusion checked each cycle.

Source files
------------

// File: rtl/srt4_pkg.sv
// Shared definitions for the radix-4 SRT divider control unit: FSM states,
// strobe bit positions, quotient-digit encoding and digit-selection thresholds.
package srt4_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT   = 4'd1,
    S_NORM   = 4'd2,
    S_STEP   = 4'd3,
    S_ADD    = 4'd4,
    S_CORR   = 4'd5,
    S_CONV   = 4'd6,
    S_DENORM = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam int NUM_C = 15;
  localparam int C0  = 0;   // clear P/A', load A
  localparam int C1  = 1;   // load B
  localparam int C2  = 2;   // normalisation shift
  localparam int C3  = 3;   // iteration shift
  localparam int C4  = 4;   // quotient digit +1
  localparam int C5  = 5;   // quotient digit -1
  localparam int C6  = 6;   // quotient digit -2
  localparam int C7  = 7;   // quotient digit +2
  localparam int C8  = 8;   // P adder write-back
  localparam int C9  = 9;   // adder subtracts
  localparam int C10 = 10;  // adder uses 2B
  localparam int C11 = 11;  // P <= P + B (correction)
  localparam int C12 = 12;  // A' <= A' + 1 (correction)
  localparam int C13 = 13;  // A <= A - A' (conversion)
  localparam int C14 = 14;  // denormalisation shift

  // Bit 2 is the sign of the digit, bit 1 flags magnitude 2.
  typedef enum logic [2:0] {
    D_0  = 3'b000,
    D_P1 = 3'b001,
    D_P2 = 3'b010,
    D_M1 = 3'b101,
    D_M2 = 3'b110
  } digit_t;

  // Lower bounds of each digit region on the signed P[8:5] estimate.
  localparam logic signed [3:0] PT_P2 = 4'sd3;
  localparam logic signed [3:0] PT_P1 = 4'sd1;
  localparam logic signed [3:0] PT_Z  = -4'sd1;
  localparam logic signed [3:0] PT_M1 = -4'sd3;

  // Adder strobes for a nonzero digit: positive digits subtract, |d|=2 uses 2B.
  function automatic logic [NUM_C-1:0] add_strobes(input digit_t d);
    logic [NUM_C-1:0] v;
    v      = '0;
    v[C8]  = 1'b1;
    v[C9]  = ~d[2];
    v[C10] = d[1];
    return v;
  endfunction

endpackage

// File: rtl/srt4_qsel.sv
// Quotient-digit selection: maps the signed remainder estimate to a radix-4
// digit and the matching one-hot quotient strobe (c4/c5/c6/c7).
module srt4_qsel
  import srt4_pkg::*;
(
  input  logic [3:0]       i_p_top,
  output logic [2:0]       o_digit,
  output logic [NUM_C-1:0] o_qmask
);

  logic signed [3:0] w_pt;
  assign w_pt = signed'(i_p_top);

  // Threshold ladder from the most positive region downwards.
  always_comb begin
    o_digit = D_0;
    o_qmask = '0;
    if (w_pt >= PT_P2) begin
      o_digit     = D_P2;
      o_qmask[C7] = 1'b1;
    end else if (w_pt >= PT_P1) begin
      o_digit     = D_P1;
      o_qmask[C4] = 1'b1;
    end else if (w_pt >= PT_Z) begin
      o_digit     = D_0;
    end else if (w_pt >= PT_M1) begin
      o_digit     = D_M1;
      o_qmask[C5] = 1'b1;
    end else begin
      o_digit     = D_M2;
      o_qmask[C6] = 1'b1;
    end
  end

endmodule

// File: rtl/srt4_ctrl_unit.sv
// Sequencer for the radix-4 SRT divider datapath. Strobes are computed for the
// state being entered and registered, so each state's strobes are visible for
// exactly the cycle the FSM spends in that state.
module srt4_ctrl_unit
  import srt4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEPS = WIDTH / 2,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        b_msb,
  input  logic        b_zero,
  input  logic [3:0]  p_top,
  input  logic        p_sign,
  output logic [14:0] c,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam int SCNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0]  NORM_MAX  = CNT_W'(WIDTH - 1);
  localparam logic [SCNT_W-1:0] STEP_LAST = SCNT_W'(STEPS);

  state_t             r_state;
  logic [NUM_C-1:0]   r_c;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [CNT_W-1:0]   r_norm_cnt;
  logic [SCNT_W-1:0]  r_step_cnt;
  digit_t             r_digit;

  state_t             w_next;
  logic [NUM_C-1:0]   w_c;
  logic               w_dbz_nxt;
  logic [CNT_W-1:0]   w_norm_nxt;
  logic [SCNT_W-1:0]  w_step_nxt;
  digit_t             w_digit_nxt;
  logic               w_go_step;
  logic               w_go_corr;
  logic [2:0]         w_qsel_digit;
  logic [NUM_C-1:0]   w_qsel_mask;

  srt4_qsel u_qsel (
    .i_p_top (p_top),
    .o_digit (w_qsel_digit),
    .o_qmask (w_qsel_mask)
  );

  // Next state plus the strobe set, counters and digit for the state entered.
  always_comb begin
    w_next      = r_state;
    w_c         = '0;
    w_dbz_nxt   = r_dbz;
    w_norm_nxt  = r_norm_cnt;
    w_step_nxt  = r_step_cnt;
    w_digit_nxt = r_digit;
    w_go_step   = 1'b0;
    w_go_corr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_INIT;
          w_c[C0]    = 1'b1;
          w_c[C1]    = 1'b1;
          w_norm_nxt = '0;
          w_step_nxt = '0;
          w_dbz_nxt  = 1'b0;
        end
      end
      S_INIT: w_next = S_NORM;
      S_NORM: begin
        if (b_zero) begin
          w_next    = S_DONE;
          w_dbz_nxt = 1'b1;
        end else if (!b_msb && (r_norm_cnt < NORM_MAX)) begin
          w_c[C2]    = 1'b1;
          w_norm_nxt = r_norm_cnt + 1'b1;
        end else begin
          w_go_step = 1'b1;
        end
      end
      S_STEP: begin
        if (r_digit != D_0) begin
          w_next = S_ADD;
          w_c    = add_strobes(r_digit);
        end else if (r_step_cnt == STEP_LAST) begin
          w_go_corr = 1'b1;
        end else begin
          w_go_step = 1'b1;
        end
      end
      S_ADD: begin
        if (r_step_cnt == STEP_LAST) w_go_corr = 1'b1;
        else                         w_go_step = 1'b1;
      end
      S_CORR: begin
        w_next   = S_CONV;
        w_c[C13] = 1'b1;
      end
      S_CONV, S_DENORM: begin
        if (r_norm_cnt != '0) begin
          w_next     = S_DENORM;
          w_c[C14]   = 1'b1;
          w_norm_nxt = r_norm_cnt - 1'b1;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Entering an iteration: the digit is chosen from the estimate present now.
    if (w_go_step) begin
      w_next      = S_STEP;
      w_c         = w_qsel_mask;
      w_c[C3]     = 1'b1;
      w_digit_nxt = digit_t'(w_qsel_digit);
      w_step_nxt  = r_step_cnt + 1'b1;
    end

    // Entering correction: a negative final remainder is restored by adding B.
    if (w_go_corr) begin
      w_next = S_CORR;
      if (p_sign) begin
        w_c[C8]  = 1'b1;
        w_c[C11] = 1'b1;
        w_c[C12] = 1'b1;
      end
    end
  end

  // State, counters and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_c        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_norm_cnt <= '0;
      r_step_cnt <= '0;
      r_digit    <= D_0;
    end else begin
      r_state    <= w_next;
      r_c        <= w_c;
      r_busy     <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done     <= (w_next == S_DONE);
      r_dbz      <= w_dbz_nxt;
      r_norm_cnt <= w_norm_nxt;
      r_step_cnt <= w_step_nxt;
      r_digit    <= w_digit_nxt;
    end
  end

  assign c           = r_c;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_srt4_ctrl_unit.sv
// Self-checking bench for srt4_ctrl_unit. A trace model builds the expected
// per-cycle strobe/status sequence of a whole division from the operation's
// parameters; the bench also plays the datapath role for b_msb.
module tb_srt4_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, b_msb, b_zero, p_sign;
  logic [3:0]  p_top;
  logic [14:0] c;
  logic        busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [14:0] c;
    logic        busy;
    logic        done;
    logic        dbz;
  } exp_t;

  exp_t q[$];

  srt4_ctrl_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .b_msb       (b_msb),
    .b_zero      (b_zero),
    .p_top       (p_top),
    .p_sign      (p_sign),
    .c           (c),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] cb(input int i);
    logic [14:0] one;
    one = 15'd1;
    return one << i;
  endfunction

  function automatic int digit_of(input int pt);
    if (pt >= 3)  return 2;
    if (pt >= 1)  return 1;
    if (pt >= -1) return 0;
    if (pt >= -3) return -1;
    return -2;
  endfunction

  function automatic logic [14:0] qbit(input int d);
    case (d)
      2:       return cb(7);
      1:       return cb(4);
      -1:      return cb(5);
      -2:      return cb(6);
      default: return 15'd0;
    endcase
  endfunction

  task automatic push(input logic [14:0] cv, input logic bsy, input logic dn, input logic dz);
    exp_t e;
    e.c = cv; e.busy = bsy; e.done = dn; e.dbz = dz;
    q.push_back(e);
  endtask

  // Expected cycle-by-cycle trace after the start edge.
  task automatic build(input int k, input bit bz, input int pt, input bit ps);
    int ks;
    int d;
    logic [14:0] addv;
    q.delete();
    ks = (k > 7) ? 7 : k;
    push(cb(0) | cb(1), 1'b1, 1'b0, 1'b0);
    push(15'd0, 1'b1, 1'b0, 1'b0);
    if (bz) begin
      push(15'd0, 1'b0, 1'b1, 1'b1);
    end else begin
      repeat (ks) push(cb(2), 1'b1, 1'b0, 1'b0);
      d = digit_of(pt);
      addv = cb(8) | ((d > 0) ? cb(9) : 15'd0) | ((d == 2 || d == -2) ? cb(10) : 15'd0);
      repeat (4) begin
        push(cb(3) | qbit(d), 1'b1, 1'b0, 1'b0);
        if (d != 0) push(addv, 1'b1, 1'b0, 1'b0);
      end
      push(ps ? (cb(8) | cb(11) | cb(12)) : 15'd0, 1'b1, 1'b0, 1'b0);
      push(cb(13), 1'b1, 1'b0, 1'b0);
      repeat (ks) push(cb(14), 1'b1, 1'b0, 1'b0);
      push(15'd0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_excl();
    check("excl_q", 32'(($countones(c[7:4]) <= 1) && (c[7:4] == 4'd0 || c[3])), 32'd1);
    check("excl_add", 32'(c[11:9] == 3'd0 || c[8]), 32'd1);
    check("excl_main", 32'($countones({c[0], c[2], c[3], c[8], c[14]}) <= 1), 32'd1);
  endtask

  // One full division; lat is the cycle (1 = first edge after start) where done rose.
  task automatic run_op(input int k, input bit bz, input int pt, input bit ps,
                        input bit hold, output int lat);
    int shifts;
    build(k, bz, pt, ps);
    start  = 1'b1;
    b_zero = bz;
    p_top  = 4'(pt);
    p_sign = ps;
    shifts = 0;
    b_msb  = (k == 0);
    lat    = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      check("c", 32'(c), 32'(q[i].c));
      check("busy", 32'(busy), 32'(q[i].busy));
      check("done", 32'(done), 32'(q[i].done));
      check("dbz", 32'(div_by_zero), 32'(q[i].dbz));
      check_excl();
      if (c[2]) shifts++;
      b_msb = (shifts >= k);
      if (done && lat == 0) lat = i + 1;
    end
    @(posedge clk);
    @(negedge clk);
    check("idle_c", 32'(c), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_dbz", 32'(div_by_zero), 32'(bz));
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; b_msb = 1'b1; b_zero = 1'b0; p_top = 4'd0; p_sign = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_c", 32'(c), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normalised divisor, all digits +2, no correction.
    run_op(0, 1'b0, 3, 1'b0, 1'b0, lat);
    check("lat_basic", 32'(lat), 32'd13);

    // Three normalisation shifts.
    run_op(3, 1'b0, 3, 1'b0, 1'b0, lat);
    check("lat_norm3", 32'(lat), 32'd19);

    // Divide by zero.
    run_op(2, 1'b1, 3, 1'b0, 1'b0, lat);
    check("lat_dbz", 32'(lat), 32'd3);

    // All-zero digits with correction; also clears div_by_zero.
    run_op(0, 1'b0, 0, 1'b1, 1'b0, lat);
    check("lat_zero_digits", 32'(lat), 32'd9);

    // Divisor msb never set: shifts cap at WIDTH-1.
    run_op(8, 1'b0, 5, 1'b0, 1'b0, lat);
    check("lat_norm_cap", 32'(lat), 32'd27);

    // Asynchronous reset in the middle of an ADD cycle.
    start = 1'b1; b_zero = 1'b0; b_msb = 1'b1; p_top = 4'd3; p_sign = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("pre_abort_c", 32'(c), 32'(cb(8) | cb(9) | cb(10)));
    #2 rst_n = 1'b0;
    #1;
    check("abort_c", 32'(c), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1, 1'b0, -4, 1'b1, 1'b0, lat);
    check("lat_after_abort", 32'(lat), 32'd15);

    // start held high through the operation and done, then back-to-back.
    run_op(0, 1'b0, 1, 1'b0, 1'b1, lat);
    check("lat_hold", 32'(lat), 32'd13);
    run_op(2, 1'b0, -2, 1'b1, 1'b0, lat);
    check("lat_b2b", 32'(lat), 32'd17);

    // Randomised operations against the trace model.
    repeat (40) begin
      int k, pt;
      bit bz, ps, hold;
      k    = int'($urandom_range(0, 8));
      pt   = int'($urandom_range(0, 15)) - 8;
      bz   = ($urandom_range(0, 5) == 0);
      ps   = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      run_op(k, bz, pt, ps, hold, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
